fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
- Round-robin scheduler that shares the single write port of the async FIFO (Asynch_FIFO write side) among NUM_REQ requesters in the write clock domain.
- Grants one requester at a time and holds the grant for a packet (until req_last) or MAX_BURST beats, whichever comes first.
- Drives write_inc/write_data straight into the FIFO and back-pressures every requester on write_full.

Parameters:
- DATADDRESS_BITS, 8, width of one data word (matches FIFO data width)
- NUM_REQ, 4, number of requesters (2..8)
- MAX_BURST, 8, maximum beats per grant before forced rotation (1..255)

Ports:
- write_clk  in  1  write-domain clock; all state on its rising edge
- write_rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATADDRESS_BITS  packed per-requester data; slice i = bits [i*DATADDRESS_BITS +: DATADDRESS_BITS]
- req_last  in  NUM_REQ  final beat of the requester's packet
- req_ready  out  NUM_REQ  beat accepted when req_valid[i] & req_ready[i]
- write_full  in  1  FIFO full flag, write domain
- write_inc  out  1  FIFO write enable
- write_data  out  DATADDRESS_BITS  FIFO write data
- grant_active  out  1  a grant is currently held
- grant_id  out  $clog2(NUM_REQ)  index of the granted requester; valid only when grant_active=1

Behaviour:
- Reset (write_rst=0, asynchronous): state=IDLE, grant_active=0, grant_id=0, rr pointer=0, beat counter=0, req_ready=0, write_inc=0.
- FSM states IDLE and GRANT:
  - IDLE: if any req_valid, pick the first asserted index at or after pointer, cyclic. Register it into grant_id and move to GRANT on the next edge. This costs one arbitration cycle, and no beat moves in IDLE.
  - GRANT: accept = req_valid[g] & !write_full.
  - Combinational outputs: req_ready[g] = !write_full, all other req_ready = 0, write_inc = accept, write_data = req_data slice g.
  - Accepted-beat latency is 0 cycles. The FIFO captures the beat on the same write_clk edge.
  - On accept, beat counter += 1.
  - Release when an accept coincides with req_last[g]=1 or with beat counter == MAX_BURST-1. On release: pointer = g+1 mod NUM_REQ, beat counter = 0, go to IDLE.
- Grant hold:
  - A granted requester that drops req_valid keeps the grant. There is no timeout, so packets stay atomic at the FIFO.
  - write_full=1 stalls the beat (write_inc=0, req_ready=0). No state changes and the beat counter holds.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,3,0,... Each grant costs at most MAX_BURST beats plus 1 idle arbitration cycle.
- Simultaneous events:
  - write_full rising in the same cycle as req_last: no accept, no release. The last beat retries.
  - A new request arriving during GRANT waits for the next IDLE.
- Width rules: beat counter is $clog2(MAX_BURST+1) bits and never wraps, because it clears at release. Pointer increment wraps modulo NUM_REQ for non-power-of-two NUM_REQ.
- Reset mid-packet: the grant is dropped immediately and the partial packet stays in the FIFO. Requesters must restart their packet after reset.
- Outputs never X after reset. write_data is don't-care when write_inc=0 but is driven with slice g.

Decomposition:
- Shared package fifo_pkg:
  - DATADDRESS_BITS and ADDRESS_BITS default constants
  - typedef logic [DATADDRESS_BITS-1:0] fifo_word_t
  - typedef enum {IDLE, GRANT} arb_state_t
- Sub-module rr_pick: combinational cyclic priority encoder. Inputs are the req vector and the pointer. Outputs are the pick index and any_valid. It is reused by the future read-side scheduler.

Test Plan:
- Single requester: NUM_REQ=4, only req 2 sends 3 beats 0x11,0x22,0x33 with last on 0x33. Required: grant_id=2 one cycle after valid, write_inc high 3 consecutive cycles with matching write_data, then grant_active=0.
- Round-robin fairness: all 4 valid, 2-beat packets. Required: FIFO contents ordered req0,req0,req1,req1,req2,req2,req3,req3, and the next grant is 0.
- Burst cap: MAX_BURST=8, req 1 sends a 20-beat packet while req 3 is also valid. Required: 8 beats of req1, then req3 is granted, then req1 resumes. Scoreboard per-requester order is intact.
- Back-pressure: force write_full=1 for 5 cycles mid-burst. Required: write_inc=0 and req_ready=0 throughout, no data lost or duplicated, and the beat counter is unchanged.
- Full with last: write_full rises in the same cycle as req_last. Required: no release. The last beat is written after full clears, and then release occurs.
- Async reset mid-packet: assert write_rst=0 between clock edges during GRANT. Required: write_inc, req_ready and grant_active go 0 immediately. After release, the first grant goes to the lowest valid index from pointer 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the async FIFO and its write/read-side schedulers.
package fifo_pkg;

  localparam int unsigned DATADDRESS_BITS = 8;
  localparam int unsigned ADDRESS_BITS    = 4;

  typedef logic [DATADDRESS_BITS-1:0] fifo_word_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority encoder: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] pick,
  output logic                       any_valid
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Extra top bit lets ptr+k exceed NUM_REQ before the explicit wrap.
      sum = {1'b0, ptr} + (IdxW+1)'(k);
      if (sum >= (IdxW+1)'(NUM_REQ)) begin
        sum = sum - (IdxW+1)'(NUM_REQ);
      end
      cand = sum[IdxW-1:0];
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin scheduler sharing the async FIFO write port; grants are held per packet
// or up to MAX_BURST beats, and every requester is back-pressured by write_full.
module fifo_write_arbiter #(
  parameter int unsigned DATADDRESS_BITS = fifo_pkg::DATADDRESS_BITS,
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_BURST       = 8
) (
  input  logic                               write_clk,
  input  logic                               write_rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*DATADDRESS_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic                               write_full,
  output logic                               write_inc,
  output logic [DATADDRESS_BITS-1:0]         write_data,
  output logic                               grant_active,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id
);

  import fifo_pkg::*;

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
  localparam logic [CntW-1:0] CapCnt  = CntW'(MAX_BURST - 1);

  arb_state_t      state_q;
  logic [IdxW-1:0] ptr_q;
  logic [CntW-1:0] beat_cnt_q;
  logic [IdxW-1:0] pick;
  logic            any_valid;
  logic            accept;
  logic            release_grant;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req      (req_valid),
    .ptr      (ptr_q),
    .pick     (pick),
    .any_valid(any_valid)
  );

  // Beats move only while a grant is held; grant_active is cleared asynchronously,
  // so a reset kills write_inc and req_ready without waiting for a clock.
  always_comb begin
    accept        = grant_active & req_valid[grant_id] & ~write_full;
    release_grant = accept & (req_last[grant_id] | (beat_cnt_q == CapCnt));
    write_inc     = accept;
    req_ready     = '0;
    if (grant_active && !write_full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    write_data = req_data[DATADDRESS_BITS-1:0];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IdxW'(i)) begin
        write_data = req_data[i*DATADDRESS_BITS +: DATADDRESS_BITS];
      end
    end
  end

  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) begin
      state_q      <= IDLE;
      grant_active <= 1'b0;
      grant_id     <= '0;
      ptr_q        <= '0;
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_id     <= pick;
            grant_active <= 1'b1;
            state_q      <= GRANT;
          end
        end
        GRANT: begin
          if (release_grant) begin
            ptr_q        <= (grant_id == LastIdx) ? '0 : grant_id + IdxW'(1);
            beat_cnt_q   <= '0;
            grant_active <= 1'b0;
            state_q      <= IDLE;
          end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q      <= IDLE;
          grant_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
